// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op/state enums and decode constants for alu_seq_unit.
// The multiplier is compiled in only when ALU_SEQ_MUL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_MUL,
    OP_ILL
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: aluop/funct to op enum, purely combinational.
// funct 011000 maps to MUL only when ALU_SEQ_MUL_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output op_t        op
);

`ifdef ALU_SEQ_MUL_EN
  localparam op_t MUL_OP = OP_MUL;
`else
  localparam op_t MUL_OP = OP_ILL;
`endif

  op_t rop;

  always_comb begin
    rop = OP_ILL;
    unique case (1'b1)
      (funct == F_ADD): rop = OP_ADD;
      (funct == F_SUB): rop = OP_SUB;
      (funct == F_AND): rop = OP_AND;
      (funct == F_OR):  rop = OP_OR;
      (funct == F_SLT): rop = OP_SLT;
      (funct == F_MUL): rop = MUL_OP;
      default:          rop = OP_ILL;
    endcase
  end

  always_comb begin
    op = OP_ILL;
    unique case (aluop)
      ALUOP_ADD:   op = OP_ADD;
      ALUOP_SUB:   op = OP_SUB;
      ALUOP_RTYPE: op = rop;
      ALUOP_ILL:   op = OP_ILL;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with IDLE/EXEC/DONE control.
// ALU_SEQ_MUL_EN adds a WIDTH-cycle shift-add multiplier.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
`endif

  alu_seq_decode u_dec (
    .aluop(aluop),
    .funct(funct),
    .op   (op)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(a) < $signed(b)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '0;
              state  <= EXEC;
            end else
`endif
            begin
              result  <= alu_res;
              zero    <= (alu_res == '0);
              illegal <= (op == OP_ILL);
              state   <= DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        EXEC: begin
          // one extra cycle at cnt == WIDTH publishes the product
          if (cnt == CW'(WIDTH)) begin
            result  <= acc;
            zero    <= (acc == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors plus a latency/queue model
// checked against the DUT every cycle (WIDTH = 32).
module tb_alu_seq_unit;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   aluop     = '0;
  logic [5:0]   funct     = '0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .aluop    (aluop),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic [W-1:0] m_result(
    input logic [1:0] op, input logic [5:0] f,
    input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'b00: return x + y;
      2'b01: return x - y;
      2'b10: begin
        case (f)
          6'b100000: return x + y;
          6'b100010: return x - y;
          6'b100100: return x & y;
          6'b100101: return x | y;
          6'b101010:
            return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`ifdef ALU_SEQ_MUL_EN
          6'b011000: return x * y;
`endif
          default:   return '0;
        endcase
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic m_illegal(
    input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00 || op == 2'b01) return 1'b0;
    if (op == 2'b11) return 1'b1;
    case (f)
      6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b101010: return 1'b0;
`ifdef ALU_SEQ_MUL_EN
      6'b011000: return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  // extra edges after the accepting edge before out_valid
  function automatic int m_lat(
    input logic [1:0] op, input logic [5:0] f);
`ifdef ALU_SEQ_MUL_EN
    if (op == 2'b10 && f == 6'b011000) return W + 1;
`endif
    return 0;
  endfunction

  logic         m_valid = 1'b0;
  logic         m_pend  = 1'b0;
  logic         m_zero  = 1'b0;
  logic         m_ill   = 1'b0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] s_res   = '0;
  logic         s_ill   = 1'b0;
  int           m_wait  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pend  <= 1'b0;
      m_res   <= '0;
      m_zero  <= 1'b0;
      m_ill   <= 1'b0;
      m_wait  <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_pend) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_pend  <= 1'b0;
        m_valid <= 1'b1;
        m_res   <= s_res;
        m_zero  <= (s_res == '0);
        m_ill   <= s_ill;
      end
    end else if (in_valid) begin
      if (m_lat(aluop, funct) == 0) begin
        m_valid <= 1'b1;
        m_res   <= m_result(aluop, funct, a, b);
        m_zero  <= (m_result(aluop, funct, a, b) == '0);
        m_ill   <= m_illegal(aluop, funct);
      end else begin
        m_pend <= 1'b1;
        m_wait <= m_lat(aluop, funct);
        s_res  <= m_result(aluop, funct, a, b);
        s_ill  <= m_illegal(aluop, funct);
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_out_valid", W'(out_valid), W'(m_valid));
    check("cyc_in_ready", W'(in_ready),
          W'(!(m_valid || m_pend)));
    check("cyc_result", result, m_res);
    check("cyc_zero", W'(zero), W'(m_zero));
    check("cyc_illegal", W'(illegal), W'(m_ill));
  end

  // ---- directed stimulus ----
  task automatic send(input logic [1:0] op, input logic [5:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    int k = 0;
    aluop    = op;
    funct    = f;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", W'(k < 100), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", W'(n < 200), W'(1));
  endtask

  task automatic op1(input string name,
                     input logic [1:0] op, input logic [5:0] f,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er,
                     input logic ez, input logic ei);
    int n;
    send(op, f, x, y);
    wait_valid(n);
    check({name, "_lat"}, W'(n), W'(0));
    check({name, "_res"}, result, er);
    check({name, "_zero"}, W'(zero), W'(ez));
    check({name, "_ill"}, W'(illegal), W'(ei));
    @(negedge clk);
    check({name, "_idle"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_result", result, W'(0));
    check("rst_zero", W'(zero), W'(0));
    check("rst_illegal", W'(illegal), W'(0));
    @(negedge clk);
    out_ready = 1'b1;

    op1("add_wrap", 2'b00, 6'h00, 32'hFFFF_FFFF, 32'h2,
        32'h1, 1'b0, 1'b0);
    check("add_idle_valid", W'(out_valid), W'(0));
    check("add_hold_res", result, 32'h1);
    op1("sub_r", 2'b10, 6'b100010, 32'd5, 32'd5,
        32'h0, 1'b1, 1'b0);
    op1("slt_neg", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1,
        32'h1, 1'b0, 1'b0);
    op1("slt_pos", 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF,
        32'h0, 1'b1, 1'b0);
    op1("sub_i", 2'b01, 6'h00, 32'd3, 32'd5,
        32'hFFFF_FFFE, 1'b0, 1'b0);
    op1("and", 2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FFFF,
        32'h00F0_1234, 1'b0, 1'b0);
    op1("or", 2'b10, 6'b100101, 32'hF000_0000, 32'h0000_000F,
        32'hF000_000F, 1'b0, 1'b0);
    op1("ill_op", 2'b11, 6'b100000, 32'd7, 32'd9,
        32'h0, 1'b1, 1'b1);
    op1("add_r", 2'b10, 6'b100000, 32'd40, 32'd2,
        32'd42, 1'b0, 1'b0);
    op1("ill_f", 2'b10, 6'b000111, 32'd7, 32'd9,
        32'h0, 1'b1, 1'b1);

`ifdef ALU_SEQ_MUL_EN
    out_ready = 1'b0;
    send(2'b10, 6'b011000, 32'd1234, 32'd5678);
    aluop    = 2'b00;
    funct    = 6'h00;
    a        = 32'd3;
    b        = 32'd4;
    in_valid = 1'b1;
    check("mul_busy_ready", W'(in_ready), W'(0));
    wait_valid(n);
    check("mul_lat", W'(n), W'(33));
    check("mul_res", result, 32'd7006652);
    check("mul_zero", W'(zero), W'(0));
    check("mul_ill", W'(illegal), W'(0));
    repeat (3) begin
      @(negedge clk);
      check("mul_stall_ready", W'(in_ready), W'(0));
      check("mul_stall_res", result, 32'd7006652);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("mul_hs_ready", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("held_add_valid", W'(out_valid), W'(1));
    check("held_add_res", result, 32'd7);
    out_ready = 1'b1;
    @(negedge clk);

    send(2'b10, 6'b011000, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_valid", W'(out_valid), W'(0));
    check("rst_exec_ready", W'(in_ready), W'(1));
    check("rst_exec_res", result, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    op1("post_rst_add", 2'b00, 6'h00, 32'd3, 32'd4,
        32'd7, 1'b0, 1'b0);
`else
    op1("mul_off", 2'b10, 6'b011000, 32'd1234, 32'd5678,
        32'h0, 1'b1, 1'b1);
`endif

    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd10, 32'd20);
    wait_valid(n);
    check("done_res", result, 32'd30);
    repeat (2) @(negedge clk);
    check("done_stall_valid", W'(out_valid), W'(1));
    check("done_stall_res", result, 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", W'(out_valid), W'(0));
    check("rst_done_res", result, W'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    op1("post_rst2_add", 2'b00, 6'h00, 32'd3, 32'd4,
        32'd7, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
